count_ah: RTL and testbench
===========================

Name: count_ah

Overview:
Mode-controlled W-bit shift-register counter with a separate SW-bit parallel state register, sharing one clock. It is the timing/state core of the SPI multiplier peripheral FSM. A one-hot 1 is parallel-loaded, then shifted left once per sclk; bit W-1 flags that W-1 bit-times have elapsed. The state register holds the FSM state code.

Parameters:
W, 9, counter/shift-register width (must be >= 2)
SW, 3, state register width (>= 1)

Ports:
clk  input  1  rising-edge clock (driven by SPI sclk in the peripheral)
reset  input  1  synchronous, active-high reset
mode  input  2  counter operation select: 2'b00 HOLD, 2'b01 LEFT, 2'b10 RIGHT, 2'b11 PLOAD
parallelIn  input  W  value loaded in PLOAD
serialIn  input  1  bit shifted in during LEFT (into bit 0) or RIGHT (into bit W-1)
parallelOut  output  W  counter/shift-register contents (registered)
countDone  output  1  combinational copy of parallelOut[W-1]
d  input  SW  next value for the state register
wrenable  input  1  state register write enable
q  output  SW  state register contents (registered)

Behaviour:
- All state updates on rising clk edge only; no asynchronous paths besides countDone = parallelOut[W-1].
- Reset (sampled at edge, reset=1): parallelOut <= 0, q <= 0; reset overrides mode and wrenable. countDone therefore 0 the cycle after reset.
- Counter, when reset=0, per edge:
  - HOLD: parallelOut unchanged.
  - LEFT: parallelOut <= {parallelOut[W-2:0], serialIn}; old bit W-1 discarded.
  - RIGHT: parallelOut <= {serialIn, parallelOut[W-1:1]}; old bit 0 discarded.
  - PLOAD: parallelOut <= parallelIn.
- Latency: every operation takes effect at the edge where mode is sampled; result visible after that edge (1 cycle).
- No wrap-around: shifting is not a rotate; once the one-hot bit leaves the MSB with serialIn=0, parallelOut becomes 0 and stays 0 under further LEFT shifts.
- One-hot timing: PLOAD 1 then N LEFT shifts with serialIn=0 gives parallelOut = 1<<N; countDone rises after exactly W-1 shifts (8 for W=9).
- Mode changes take effect at the next edge; no pipelining or handshake.
- State register, when reset=0: wrenable=1 -> q <= d; wrenable=0 -> q holds.
- Counter and state register are independent: simultaneous mode activity and wrenable both apply at the same edge.
- Unknown/X mode bits: treated as HOLD (no change) in synthesis-equivalent RTL; must not corrupt q.
- Power-up before first reset: undefined; users must assert reset for at least one edge.

Test Plan:
- Reset: drive parallelOut to 9'h1FF via PLOAD and q to 3'd5, assert reset one edge with mode=LEFT, wrenable=1, d=3'd7 -> parallelOut=0, q=0, countDone=0.
- One-hot count: PLOAD parallelIn=9'h001, then LEFT with serialIn=0 for 8 edges -> parallelOut = 9'h002...9'h100, countDone goes 1 on the 8th shift only; 9th shift -> 9'h000, countDone=0.
- Serial shift: PLOAD 0, LEFT 9 edges with serialIn pattern 1,0,1,1,0,0,1,0,1 -> parallelOut=9'b101100101; then RIGHT 1 edge with serialIn=1 -> 9'b110110010.
- HOLD: load 9'h0A5, mode HOLD for 5 edges with serialIn toggling -> parallelOut stays 9'h0A5.
- State register: wrenable=1,d=3'd1 -> q=1; wrenable=0,d=3'd4 for 3 edges -> q stays 1; wrenable=1,d=3'd4 -> q=4, while counter simultaneously shifts correctly.
- Reset mid-shift: after PLOAD 1 and 4 LEFT shifts (9'h010), assert reset -> 9'h000; deassert, PLOAD 1 -> 9'h001 and counting restarts.

Source files
------------

// File: rtl/count_ah.sv
// ---------------------------------------------------------------------------
// count_ah
//
// Timing/state core of the SPI multiplier peripheral FSM. It contains two
// independent registers that share one clock:
//
//   * A W-bit shift-register counter. Software parallel-loads a one-hot 1 and
//     then shifts it left once per sclk. When the 1 reaches bit W-1, W-1
//     bit-times have elapsed and countDone is raised.
//   * An SW-bit state register that holds the FSM state code.
//
// Ports
//   clk          rising-edge clock (SPI sclk in the peripheral)
//   reset        synchronous, active-high; clears both registers
//   mode         counter operation: 00 HOLD, 01 LEFT, 10 RIGHT, 11 PLOAD
//   parallelIn   value loaded into the counter in PLOAD
//   serialIn     bit shifted into bit 0 (LEFT) or bit W-1 (RIGHT)
//   parallelOut  registered counter contents
//   countDone    combinational copy of parallelOut[W-1]
//   d            next value for the state register
//   wrenable     state register write enable
//   q            registered state register contents
// ---------------------------------------------------------------------------
module count_ah #(
  parameter int W  = 9,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  parallelIn,
  input  logic          serialIn,
  output logic [W-1:0]  parallelOut,
  output logic          countDone,
  input  logic [SW-1:0] d,
  input  logic          wrenable,
  output logic [SW-1:0] q
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_PLOAD = 2'b11
  } mode_e;

  logic [W-1:0]  cnt_reg;
  logic [W-1:0]  cnt_next;
  logic [SW-1:0] state_reg;
  logic [SW-1:0] state_next;

  // Counter next value. Shifts are plain shifts, never rotates: the bit that
  // falls off the end is discarded. Any mode value that does not match one
  // of the four codes (e.g. X in simulation) lands in the default branch and
  // holds the counter.
  always_comb begin
    cnt_next = cnt_reg;
    case (mode)
      MODE_HOLD:  cnt_next = cnt_reg;
      MODE_LEFT:  cnt_next = {cnt_reg[W-2:0], serialIn};
      MODE_RIGHT: cnt_next = {serialIn, cnt_reg[W-1:1]};
      MODE_PLOAD: cnt_next = parallelIn;
      default:    cnt_next = cnt_reg;
    endcase
  end

  // State register next value; it does not look at mode at all, so counter
  // activity and state writes can happen at the same edge.
  always_comb begin
    state_next = state_reg;
    if (wrenable) begin
      state_next = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      state_reg <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
    end
  end

  assign parallelOut = cnt_reg;
  assign countDone   = cnt_reg[W-1];
  assign q           = state_reg;

endmodule

// File: tb/tb_count_ah.sv
// ---------------------------------------------------------------------------
// tb_count_ah
//
// Directed steps following the counter's usage scenarios, then a randomized
// run. Every edge is checked against a reference model that treats the
// counter as an integer (LEFT = double plus serial bit modulo 2**W, RIGHT =
// halve plus serial bit weighted 2**(W-1)); directed steps also compare
// against literal expected values.
// ---------------------------------------------------------------------------
module tb_count_ah;
  localparam int W  = 9;
  localparam int SW = 3;

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;
  localparam logic [1:0] PLOAD = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [W-1:0]  parallelIn;
  logic          serialIn;
  logic [W-1:0]  parallelOut;
  logic          countDone;
  logic [SW-1:0] d;
  logic          wrenable;
  logic [SW-1:0] q;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_cnt;
  int m_q;

  count_ah #(.W(W), .SW(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .parallelIn (parallelIn),
    .serialIn   (serialIn),
    .parallelOut(parallelOut),
    .countDone  (countDone),
    .d          (d),
    .wrenable   (wrenable),
    .q          (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one edge of stimulus, advance the model, compare all outputs.
  task automatic step(input logic [1:0] md, input logic [W-1:0] pin,
                      input logic si, input logic [SW-1:0] dd,
                      input logic we, input logic rst, input string tag);
    @(negedge clk);
    mode       = md;
    parallelIn = pin;
    serialIn   = si;
    d          = dd;
    wrenable   = we;
    reset      = rst;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_q   = 0;
    end else begin
      case (md)
        LEFT:    m_cnt = (m_cnt * 2 + int'(si)) % (1 << W);
        RIGHT:   m_cnt = m_cnt / 2 + (si ? (1 << (W - 1)) : 0);
        PLOAD:   m_cnt = int'(pin);
        default: m_cnt = m_cnt;
      endcase
      if (we) m_q = int'(dd);
    end
    #1;
    check({tag, ".parallelOut"}, int'(parallelOut), m_cnt);
    check({tag, ".countDone"},   int'(countDone),   (m_cnt >> (W - 1)) & 1);
    check({tag, ".q"},           int'(q),           m_q);
    $display("%0t %s mode=%b pin=%h si=%b d=%0d we=%b rst=%b -> out=%h done=%b q=%0d",
             $time, tag, md, pin, si, dd, we, rst, parallelOut, countDone, q);
  endtask

  initial begin
    logic [8:0] pattern;
    m_cnt      = 0;
    m_q        = 0;
    reset      = 1'b1;
    mode       = HOLD;
    parallelIn = '0;
    serialIn   = 1'b0;
    d          = '0;
    wrenable   = 1'b0;

    // Power-up reset
    step(HOLD, 9'h000, 1'b0, 3'd0, 1'b0, 1'b1, "init_reset");
    check("init.out", int'(parallelOut), 0);
    check("init.q",   int'(q),           0);

    // Reset overrides mode and wrenable
    step(PLOAD, 9'h1FF, 1'b0, 3'd5, 1'b1, 1'b0, "load_1ff");
    check("load_1ff.out", int'(parallelOut), 'h1FF);
    check("load_1ff.q",   int'(q),           5);
    step(LEFT, 9'h000, 1'b1, 3'd7, 1'b1, 1'b1, "reset_override");
    check("reset_override.out",  int'(parallelOut), 0);
    check("reset_override.q",    int'(q),           0);
    check("reset_override.done", int'(countDone),   0);

    // One-hot count: countDone only on the 8th shift, 9th shift empties
    step(PLOAD, 9'h001, 1'b0, 3'd0, 1'b0, 1'b0, "onehot_load");
    for (int n = 1; n <= 9; n++) begin
      step(LEFT, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0, $sformatf("onehot_shift%0d", n));
      check($sformatf("onehot%0d.out", n),  int'(parallelOut), (n < 9) ? (1 << n) : 0);
      check($sformatf("onehot%0d.done", n), int'(countDone),   (n == 8) ? 1 : 0);
    end
    // Stays empty under further LEFT shifts
    step(LEFT, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0, "onehot_empty");
    check("onehot_empty.out", int'(parallelOut), 0);

    // Serial shift-in pattern, then one RIGHT shift
    step(PLOAD, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0, "serial_clear");
    pattern = 9'b101100101;
    for (int i = 8; i >= 0; i--) begin
      step(LEFT, 9'h000, pattern[i], 3'd0, 1'b0, 1'b0, $sformatf("serial_in%0d", 8 - i));
    end
    check("serial.out", int'(parallelOut), 'b101100101);
    step(RIGHT, 9'h000, 1'b1, 3'd0, 1'b0, 1'b0, "serial_right");
    check("serial_right.out", int'(parallelOut), 'b110110010);

    // HOLD with serialIn toggling
    step(PLOAD, 9'h0A5, 1'b0, 3'd0, 1'b0, 1'b0, "hold_load");
    for (int i = 0; i < 5; i++) begin
      step(HOLD, 9'h1FF, i[0], 3'd0, 1'b0, 1'b0, $sformatf("hold%0d", i));
      check($sformatf("hold%0d.out", i), int'(parallelOut), 'h0A5);
    end

    // State register alongside counter activity
    step(PLOAD, 9'h001, 1'b0, 3'd1, 1'b1, 1'b0, "state_wr1");
    check("state_wr1.q", int'(q), 1);
    for (int i = 0; i < 3; i++) begin
      step(LEFT, 9'h000, 1'b0, 3'd4, 1'b0, 1'b0, $sformatf("state_hold%0d", i));
      check($sformatf("state_hold%0d.q", i), int'(q), 1);
    end
    step(LEFT, 9'h000, 1'b0, 3'd4, 1'b1, 1'b0, "state_wr4");
    check("state_wr4.q",   int'(q),           4);
    check("state_wr4.out", int'(parallelOut), 'h010);

    // Reset mid-shift, then restart
    step(PLOAD, 9'h001, 1'b0, 3'd0, 1'b0, 1'b0, "mid_load");
    for (int i = 0; i < 4; i++) begin
      step(LEFT, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0, $sformatf("mid_shift%0d", i));
    end
    check("mid_shift.out", int'(parallelOut), 'h010);
    step(LEFT, 9'h000, 1'b0, 3'd0, 1'b0, 1'b1, "mid_reset");
    check("mid_reset.out", int'(parallelOut), 0);
    step(PLOAD, 9'h001, 1'b0, 3'd0, 1'b0, 1'b0, "mid_reload");
    check("mid_reload.out", int'(parallelOut), 'h001);
    step(LEFT, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0, "mid_restart");
    check("mid_restart.out", int'(parallelOut), 'h002);

    // Randomized run against the model
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 9'($urandom), 1'($urandom),
           3'($urandom), 1'($urandom), ($urandom_range(0, 24) == 0),
           $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
